// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   - RV32 opcode constants for the supported instruction subset
//   - FSM state enum
//   - encodings for Imm_sel, Alu_sel and Wb_Sel
//   - decode result structs shared by ctrl_decode and main_ctrl
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_MEM  = 2'b00,
        WB_ALU  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    // Datapath select lines, held stable from DECODE through WB.
    typedef struct packed {
        imm_sel_e imm_sel;
        alu_sel_e alu_sel;
        logic     a_sel;
        logic     b_sel;
        wb_sel_e  wb_sel;
    } sel_t;

    // Full decode result: select lines plus the flags that steer the FSM.
    typedef struct packed {
        sel_t sel;
        logic reg_we;
        logic is_mem;
        logic is_sw;
        logic is_beq;
        logic is_jal;
        logic illegal;
    } dec_t;

    localparam sel_t SEL_ZERO = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode/funct decoder.
// Ports:
//   inst_i  in  32     instruction word to decode
//   dec_o   out dec_t  select lines, FSM steering flags and illegal flag
// Any opcode/funct combination outside the supported subset yields an
// all-zero result with only the illegal flag set.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    // Register specifiers and immediates are datapath concerns only.
    assign unused_fields = ^inst_i[24:15] ^ ^inst_i[11:7];

    always_comb begin
        dec_o = '0;
        case (opcode)
            OP_R: begin
                dec_o.sel.wb_sel = WB_ALU;
                dec_o.reg_we     = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_o.sel.alu_sel = ALU_ADD;
                    {7'b0100000, 3'b000}: dec_o.sel.alu_sel = ALU_SUB;
                    {7'b0000000, 3'b111}: dec_o.sel.alu_sel = ALU_AND;
                    {7'b0000000, 3'b110}: dec_o.sel.alu_sel = ALU_OR;
                    default: begin
                        dec_o         = '0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OP_I: begin
                dec_o.sel.imm_sel = IMM_I;
                dec_o.sel.b_sel   = 1'b1;
                dec_o.sel.wb_sel  = WB_ALU;
                dec_o.reg_we      = 1'b1;
                case (funct3)
                    3'b000:  dec_o.sel.alu_sel = ALU_ADD;
                    3'b111:  dec_o.sel.alu_sel = ALU_AND;
                    3'b110:  dec_o.sel.alu_sel = ALU_OR;
                    default: begin
                        dec_o         = '0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                if (funct3 == 3'b010) begin
                    dec_o.sel.imm_sel = IMM_I;
                    dec_o.sel.b_sel   = 1'b1;
                    dec_o.sel.alu_sel = ALU_ADD;
                    dec_o.sel.wb_sel  = WB_MEM;
                    dec_o.reg_we      = 1'b1;
                    dec_o.is_mem      = 1'b1;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OP_SW: begin
                if (funct3 == 3'b010) begin
                    dec_o.sel.imm_sel = IMM_S;
                    dec_o.sel.b_sel   = 1'b1;
                    dec_o.sel.alu_sel = ALU_ADD;
                    dec_o.is_mem      = 1'b1;
                    dec_o.is_sw       = 1'b1;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OP_BEQ: begin
                if (funct3 == 3'b000) begin
                    dec_o.sel.imm_sel = IMM_B;
                    dec_o.sel.a_sel   = 1'b1;
                    dec_o.sel.b_sel   = 1'b1;
                    dec_o.sel.alu_sel = ALU_ADD;
                    dec_o.is_beq      = 1'b1;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                dec_o.sel.imm_sel = IMM_J;
                dec_o.sel.a_sel   = 1'b1;
                dec_o.sel.b_sel   = 1'b1;
                dec_o.sel.alu_sel = ALU_ADD;
                dec_o.sel.wb_sel  = WB_PC4;
                dec_o.reg_we      = 1'b1;
                dec_o.is_jal      = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/main_ctrl.sv
// main_ctrl: multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) for a
// small RV32 subset. All outputs are registered.
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   inst         in   WIDTH  instruction word at current PC
//   BEQ          in   1      rs1 == rs2 flag, sampled at the end of EXEC
//   Imm_sel      out  2      immediate format
//   Alu_sel      out  2      ALU operation
//   A_sel/B_sel  out  1      ALU operand sources
//   Pc_sel       out  1      next-PC source (valid in WB)
//   Reg_we       out  1      register-file write, one cycle in WB
//   Mem_we       out  1      data-memory write, one cycle in MEM (sw)
//   Wb_Sel       out  2      write-back source
//   pc_we        out  1      PC update, one pulse per retired instruction
//   halt         out  1      sticky illegal-instruction flag
//   cycle_cnt    out  WIDTH  active-cycle counter   (MAIN_CTRL_PERF_EN only)
//   instret_cnt  out  WIDTH  retired-instr counter  (MAIN_CTRL_PERF_EN only)
// Optional feature macro: MAIN_CTRL_PERF_EN adds the performance counters.
module main_ctrl
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inst,
    input  logic             BEQ,
    output logic [1:0]       Imm_sel,
    output logic [1:0]       Alu_sel,
    output logic             A_sel,
    output logic             B_sel,
    output logic             Pc_sel,
    output logic             Reg_we,
    output logic             Mem_we,
    output logic [1:0]       Wb_Sel,
    output logic             pc_we,
    output logic             halt
`ifdef MAIN_CTRL_PERF_EN
    ,
    output logic [WIDTH-1:0] cycle_cnt,
    output logic [WIDTH-1:0] instret_cnt
`endif
);

    state_e           state_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] ir_d;
    logic             beq_q;
    sel_t             sel_q;
    dec_t             dec;

    // In FETCH the decoder looks at the word being latched so the select
    // registers can already hold decoded values on entry to DECODE; in every
    // other state this is just the instruction register.
    assign ir_d = (state_q == FETCH) ? inst : ir_q;

    ctrl_decode u_decode (
        .inst_i (ir_d[31:0]),
        .dec_o  (dec)
    );

    assign Imm_sel = sel_q.imm_sel;
    assign Alu_sel = sel_q.alu_sel;
    assign A_sel   = sel_q.a_sel;
    assign B_sel   = sel_q.b_sel;
    assign Wb_Sel  = sel_q.wb_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q    <= '0;
            beq_q   <= 1'b0;
            sel_q   <= SEL_ZERO;
            Pc_sel  <= 1'b0;
            Reg_we  <= 1'b0;
            Mem_we  <= 1'b0;
            pc_we   <= 1'b0;
            halt    <= 1'b0;
        end else begin
            // Strobes default low: each is a single-cycle pulse.
            Pc_sel <= 1'b0;
            Reg_we <= 1'b0;
            Mem_we <= 1'b0;
            pc_we  <= 1'b0;
            case (state_q)
                FETCH: begin
                    ir_q    <= inst;
                    sel_q   <= dec.sel;
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (dec.illegal) begin
                        sel_q   <= SEL_ZERO;
                        halt    <= 1'b1;
                        state_q <= HALT;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    beq_q <= BEQ;
                    if (dec.is_mem) begin
                        Mem_we  <= dec.is_sw;
                        state_q <= MEM;
                    end else begin
                        // Branch decision uses BEQ as it is being registered.
                        Reg_we  <= dec.reg_we;
                        pc_we   <= 1'b1;
                        Pc_sel  <= dec.is_jal | (dec.is_beq & BEQ);
                        state_q <= WB;
                    end
                end
                MEM: begin
                    Reg_we  <= dec.reg_we;
                    pc_we   <= 1'b1;
                    Pc_sel  <= dec.is_jal | (dec.is_beq & beq_q);
                    state_q <= WB;
                end
                WB: begin
                    sel_q   <= SEL_ZERO;
                    state_q <= FETCH;
                end
                HALT: begin
                    sel_q   <= SEL_ZERO;
                    state_q <= HALT;
                end
                default: begin
                    sel_q   <= SEL_ZERO;
                    state_q <= FETCH;
                end
            endcase
        end
    end

`ifdef MAIN_CTRL_PERF_EN
    logic [WIDTH-1:0] cycle_cnt_q;
    logic [WIDTH-1:0] instret_cnt_q;

    // Both counters wrap naturally at 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != HALT) cycle_cnt_q <= cycle_cnt_q + WIDTH'(1);
            if (pc_we)           instret_cnt_q <= instret_cnt_q + WIDTH'(1);
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_main_ctrl.sv
// tb_main_ctrl: directed self-checking bench for main_ctrl.
// Observed output vector layout (13 bits):
//   {Imm_sel[1:0], Alu_sel[1:0], A_sel, B_sel, Wb_Sel[1:0],
//    Pc_sel, Reg_we, Mem_we, pc_we, halt}
// Cycle 1 of an instruction is the FETCH cycle.
module tb_main_ctrl;

    localparam int WIDTH = 32;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h40208233;
    localparam logic [31:0] I_AND  = 32'h0020F233;
    localparam logic [31:0] I_OR   = 32'h0020E233;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ANDI = 32'h0050F093;
    localparam logic [31:0] I_ORI  = 32'h0050E093;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;
    localparam logic [31:0] I_SLL  = 32'h00209233;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             BEQ   = 1'b0;
    logic [WIDTH-1:0] inst  = '0;
    logic [1:0]       Imm_sel, Alu_sel, Wb_Sel;
    logic             A_sel, B_sel, Pc_sel, Reg_we, Mem_we, pc_we, halt;
`ifdef MAIN_CTRL_PERF_EN
    logic [WIDTH-1:0] cycle_cnt, instret_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [12:0] cap [1:8];

    always #5 clk = ~clk;

    main_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inst    (inst),
        .BEQ     (BEQ),
        .Imm_sel (Imm_sel),
        .Alu_sel (Alu_sel),
        .A_sel   (A_sel),
        .B_sel   (B_sel),
        .Pc_sel  (Pc_sel),
        .Reg_we  (Reg_we),
        .Mem_we  (Mem_we),
        .Wb_Sel  (Wb_Sel),
        .pc_we   (pc_we),
        .halt    (halt)
`ifdef MAIN_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    wire [12:0] obs = {Imm_sel, Alu_sel, A_sel, B_sel, Wb_Sel,
                       Pc_sel, Reg_we, Mem_we, pc_we, halt};

    function automatic logic [12:0] v(input logic [1:0] imm, input logic [1:0] alu,
                                      input logic a, input logic b, input logic [1:0] wb,
                                      input logic pcs, input logic rw, input logic mw,
                                      input logic pw, input logic h);
        return {imm, alu, a, b, wb, pcs, rw, mw, pw, h};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Run one instruction for n cycles, capturing outputs each cycle.
    // BEQ carries b only during cycle 3 (EXEC) and the opposite otherwise.
    task automatic run(input logic [31:0] ins, input int n, input logic b);
        for (int c = 1; c <= n; c++) begin
            inst  = ins;
            BEQ   = (c == 3) ? b : ~b;
            cap[c] = obs;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inst  = I_ADD;
        step();
        step();
        tests++;
        if (obs !== 13'h0) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", obs, 13'h0);
        end
        rst_n = 1'b1;
        tests++;
        if (obs !== 13'h0) begin
            fails++;
            $display("FAIL reset_release: got %h expected %h", obs, 13'h0);
        end
`ifdef MAIN_CTRL_PERF_EN
        tests++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
`endif
    endtask

    task automatic test_alu_ops();
        logic [31:0] tab_i [7];
        logic [1:0]  tab_a [7];
        logic        tab_b [7];
        logic [12:0] e;
        tab_i = '{I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_ANDI, I_ORI};
        tab_a = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
        tab_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            run(tab_i[k], 4, 1'b0);
            for (int c = 1; c <= 4; c++) begin
                e = (c == 1) ? 13'h0 :
                    v(2'b00, tab_a[k], 1'b0, tab_b[k], 2'b01,
                      1'b0, c == 4, 1'b0, c == 4, 1'b0);
                tests++;
                if (cap[c] !== e) begin
                    fails++;
                    $display("FAIL alu%0d_c%0d: got %h expected %h", k, c, cap[c], e);
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [12:0] e;
        run(I_LW, 5, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            e = (c == 1) ? 13'h0 :
                v(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, c == 5, 1'b0, c == 5, 1'b0);
            tests++;
            if (cap[c] !== e) begin
                fails++;
                $display("FAIL lw_c%0d: got %h expected %h", c, cap[c], e);
            end
        end
        run(I_SW, 5, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            e = (c == 1) ? 13'h0 :
                v(2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, c == 4, c == 5, 1'b0);
            tests++;
            if (cap[c] !== e) begin
                fails++;
                $display("FAIL sw_c%0d: got %h expected %h", c, cap[c], e);
            end
        end
    endtask

    task automatic test_beq();
        logic [12:0] e;
        for (int t = 0; t < 2; t++) begin
            logic taken;
            taken = (t == 0);
            run(I_BEQ, 4, taken);
            for (int c = 1; c <= 4; c++) begin
                e = (c == 1) ? 13'h0 :
                    v(2'b10, 2'b00, 1'b1, 1'b1, 2'b00,
                      (c == 4) && taken, 1'b0, 1'b0, c == 4, 1'b0);
                tests++;
                if (cap[c] !== e) begin
                    fails++;
                    $display("FAIL beq%0d_c%0d: got %h expected %h", taken, c, cap[c], e);
                end
            end
        end
    endtask

    task automatic test_jal();
        logic [12:0] e;
        run(I_JAL, 4, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            e = (c == 1) ? 13'h0 :
                v(2'b11, 2'b00, 1'b1, 1'b1, 2'b10, c == 4, c == 4, 1'b0, c == 4, 1'b0);
            tests++;
            if (cap[c] !== e) begin
                fails++;
                $display("FAIL jal_c%0d: got %h expected %h", c, cap[c], e);
            end
        end
    endtask

    task automatic test_illegal();
        logic [12:0] hv;
        hv = v(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run(I_ILL, 8, 1'b1);
        tests++;
        if (cap[1] !== 13'h0) begin
            fails++;
            $display("FAIL ill_c1: got %h expected %h", cap[1], 13'h0);
        end
        for (int c = 3; c <= 8; c++) begin
            tests++;
            if (cap[c] !== hv) begin
                fails++;
                $display("FAIL ill_c%0d: got %h expected %h", c, cap[c], hv);
            end
        end
        // One reset edge leaves HALT and clears halt.
        do_reset(1);
        tests++;
        if (obs !== 13'h0) begin
            fails++;
            $display("FAIL ill_reset: got %h expected %h", obs, 13'h0);
        end
        run(I_ADD, 4, 1'b0);
        tests++;
        if (cap[4] !== v(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)) begin
            fails++;
            $display("FAIL ill_recover: got %h expected %h", cap[4],
                     v(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        // Legal opcode with an unsupported funct3 also halts.
        run(I_SLL, 4, 1'b0);
        for (int c = 3; c <= 4; c++) begin
            tests++;
            if (cap[c] !== hv) begin
                fails++;
                $display("FAIL sll_c%0d: got %h expected %h", c, cap[c], hv);
            end
        end
        do_reset(1);
    endtask

    task automatic test_reset_inflight();
        // Reset while sw is in MEM.
        run(I_SW, 3, 1'b0);
        tests++;
        if (Mem_we !== 1'b1) begin
            fails++;
            $display("FAIL abort_mem_pre: got %b expected 1", Mem_we);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++;
        if (obs !== 13'h0) begin
            fails++;
            $display("FAIL abort_mem: got %h expected %h", obs, 13'h0);
        end
        // Reset while lw is in WB.
        run(I_LW, 4, 1'b0);
        tests++;
        if (Reg_we !== 1'b1 || pc_we !== 1'b1) begin
            fails++;
            $display("FAIL abort_wb_pre: got %b%b expected 11", Reg_we, pc_we);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++;
        if (obs !== 13'h0) begin
            fails++;
            $display("FAIL abort_wb: got %h expected %h", obs, 13'h0);
        end
    endtask

`ifdef MAIN_CTRL_PERF_EN
    task automatic test_perf();
        do_reset(1);
        run(I_ADD, 4, 1'b0);
        run(I_ADD, 4, 1'b0);
        run(I_ADD, 4, 1'b0);
        tests++;
        if (instret_cnt !== WIDTH'(3)) begin
            fails++;
            $display("FAIL perf_instret: got %0d expected 3", instret_cnt);
        end
        tests++;
        if (cycle_cnt !== WIDTH'(12)) begin
            fails++;
            $display("FAIL perf_cycle: got %0d expected 12", cycle_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_load_store();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_inflight();
`ifdef MAIN_CTRL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/main_ctrl.md
MAIN_CTRL -- requirements
Module: main_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: datapath word width and performance-counter width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port inst  input  WIDTH  instruction word from instruction memory at the current PC.
REQ-005 SHALL have port BEQ  input  1  datapath equality flag, rs1 == rs2.
REQ-006 SHALL have port Imm_sel  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have port Alu_sel  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 SHALL have ports A_sel / B_sel  output  1 each  A: 0 rs1, 1 PC; B: 0 rs2, 1 imm.
REQ-009 SHALL have port Pc_sel  output  1  next-PC source: 0 pc_plus4, 1 ALU result.
REQ-010 SHALL have ports Reg_we / Mem_we  output  1 each  register-file and data-memory write enables.
REQ-011 SHALL have port Wb_Sel  output  2  write-back source: 00 memory, 01 ALU, 10 pc_plus4.
REQ-012 SHALL have port pc_we  output  1  PC update enable; one pulse per retired instruction.
REQ-013 SHALL have port halt  output  1  sticky flag, set on an illegal instruction.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 SHALL latch inst into an internal instruction register in FETCH; all decode uses the latched value.
REQ-016 SHALL transition FETCH->DECODE->EXEC unconditionally.
REQ-017 SHALL transition EXEC->MEM for lw/sw and EXEC->WB otherwise; MEM->WB; WB->FETCH.
REQ-018 SHALL decode opcode 0110011 with funct7[5]/funct3 as add, sub, and, or, to Alu_sel 00/01/10/11, B_sel 0, Wb_Sel 01, with a register write.
REQ-019 SHALL decode opcode 0010011 with funct3 000/111/110 as addi/andi/ori, with Imm_sel 00, B_sel 1, Wb_Sel 01, and a register write.
REQ-020 SHALL decode lw (0000011) as Imm_sel 00, B_sel 1, ADD, Wb_Sel 00, with a register write; sw (0100011) as Imm_sel 01, B_sel 1, ADD, with no register write.
REQ-021 SHALL decode beq (1100011, funct3 000) as Imm_sel 10, A_sel 1, B_sel 1, ADD, with no register write.
REQ-022 SHALL decode jal (1101111) as Imm_sel 11, A_sel 1, B_sel 1, ADD, Wb_Sel 10, with a register write.
REQ-023 SHALL hold the select outputs (Imm_sel, Alu_sel, A_sel, B_sel, Wb_Sel) at the decoded values from DECODE through WB, and at 0 in FETCH and HALT.
REQ-024 SHALL assert Mem_we for exactly one cycle, in MEM, for sw only.
REQ-025 SHALL assert Reg_we for exactly one cycle, in WB, for instructions with a register write.
REQ-026 SHALL assert pc_we for exactly one cycle, in WB, for every legal instruction.
REQ-027 SHALL register BEQ at the end of EXEC; in WB, Pc_sel = 1 for jal or (beq and registered BEQ), and 0 otherwise.
REQ-028 SHALL give latency in cycles: lw and sw 5, all others 4.
REQ-029 SHALL, on any unlisted opcode/funct combination in DECODE, go to HALT and set halt.
REQ-030 SHALL keep HALT until reset, with Reg_we, Mem_we, pc_we and Pc_sel all 0.

Reset
REQ-031 SHALL, while rst_n = 0 at a clock edge, enter FETCH, clear the instruction register, the registered BEQ and halt, and drive every output to 0.
REQ-032 SHALL abort an in-flight instruction on reset in any state, including MEM and WB, with no write enable asserted in the following cycle.

Configuration
REQ-033 SHALL, with macro MAIN_CTRL_PERF_EN defined, add outputs cycle_cnt and instret_cnt (WIDTH each, output).
REQ-034 SHALL, under MAIN_CTRL_PERF_EN, increment cycle_cnt every cycle outside reset and HALT, and instret_cnt on each pc_we pulse; both wrap modulo 2^WIDTH and clear on reset.
REQ-035 SHALL, without MAIN_CTRL_PERF_EN, have neither the counters nor the ports.

Structure
REQ-036 SHALL take from shared package ctrl_pkg: opcode constants, the state enum, and the Imm_sel/Alu_sel/Wb_Sel encodings.
REQ-037 SHALL place the combinational opcode/funct decode in sub-module ctrl_decode, with the FSM and registers in main_ctrl.

Verification
REQ-038 SHALL cover: add x3,x1,x2 (0x002081B3) -> Alu_sel 00, B_sel 0, Wb_Sel 01; Reg_we and pc_we high in cycle 4 only.
REQ-039 SHALL cover: lw (0x0000A183) then sw (0x0030A023) -> lw: Reg_we in cycle 5, Wb_Sel 00; sw: Mem_we in cycle 4, pc_we in cycle 5, no Reg_we.
REQ-040 SHALL cover: beq with BEQ=1 in EXEC -> Pc_sel 1 in WB; with BEQ=0 -> Pc_sel 0; neither case asserts Reg_we.
REQ-041 SHALL cover: jal (0x008000EF) -> Imm_sel 11, A_sel 1, Wb_Sel 10, Pc_sel 1, and Reg_we in WB.
REQ-042 SHALL cover: inst 0xFFFFFFFF -> halt = 1 after DECODE, no further pc_we; rst_n low for one edge -> FETCH with halt = 0.
REQ-043 SHALL cover: rst_n low during MEM of sw -> Mem_we 0 on the next cycle; with MAIN_CTRL_PERF_EN, 3 retired add instructions -> instret_cnt = 3, cycle_cnt = 12.
